// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I core: PCF, imem request handshake, 1-entry skid buffer,
// redirect/discard handling and the IF/ID register. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrcE,
    input  logic            PCJalSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     discard_cnt,
`endif
    output logic            ValidD
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } fetchState_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
    } ifIdEntry_t;

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pcReg;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] discardAddr;
    logic [XLEN-1:0] discardAddrNext;
    ifIdEntry_t      ifId;
    ifIdEntry_t      ifIdNext;
    ifIdEntry_t      skidReg;
    ifIdEntry_t      skidNext;
    logic            ifIdValid;
    logic            ifIdValidNext;
    logic            skidFull;
    logic            skidFullNext;

    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] redirectRaw;
    logic [XLEN-1:0] redirectTarget;
    logic            accept;
    logic            committed;

    assign pcPlus4        = pcReg + XLEN'(4);
    assign redirectRaw    = PCJalSrcE ? ALUResultE : PCTargetE;
    assign redirectTarget = redirectRaw & ~XLEN'(3);

    // Only FETCH consumes responses; DISCARD responses are always dropped.
    assign accept    = (state == FETCH) && !skidFull && imem_ready;
    assign committed = (state == FETCH) && !skidFull && !imem_ready;

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pcReg         <= RESET_PC;
            discardAddr   <= '0;
            ifId.instr    <= NOP_INSTR;
            ifId.pc       <= '0;
            ifId.pcPlus4  <= '0;
            ifIdValid     <= 1'b0;
            skidReg       <= '0;
            skidFull      <= 1'b0;
        end else begin
            state         <= stateNext;
            pcReg         <= pcNext;
            discardAddr   <= discardAddrNext;
            ifId          <= ifIdNext;
            ifIdValid     <= ifIdValidNext;
            skidReg       <= skidNext;
            skidFull      <= skidFullNext;
        end
    end

    // Next-state, request and IF/ID update; priority redirect > FlushD > StallD > accept.
    always_comb begin
        stateNext       = state;
        pcNext          = pcReg;
        discardAddrNext = discardAddr;
        ifIdNext        = ifId;
        ifIdValidNext   = ifIdValid;
        skidNext        = skidReg;
        skidFullNext    = skidFull;
        imem_req        = 1'b0;
        imem_addr       = pcReg;

        case (state)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                imem_req = !skidFull;
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = discardAddr;
                if (imem_ready) begin
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (PCSrcE) begin
            // Wrong-path data (accepted or still outstanding) never reaches IF/ID.
            pcNext         = redirectTarget;
            skidFullNext   = 1'b0;
            ifIdNext.instr = NOP_INSTR;
            ifIdValidNext  = 1'b0;
            if (committed) begin
                discardAddrNext = pcReg;
                stateNext       = DISCARD;
            end
        end else if (FlushD) begin
            // PCF holds, so a response accepted under flush is simply fetched again.
            ifIdNext.instr = NOP_INSTR;
            ifIdValidNext  = 1'b0;
        end else if (StallD) begin
            if (accept) begin
                skidNext.instr   = imem_rdata;
                skidNext.pc      = pcReg;
                skidNext.pcPlus4 = pcPlus4;
                skidFullNext     = 1'b1;
                pcNext           = pcPlus4;
            end
        end else if (skidFull) begin
            ifIdNext      = skidReg;
            ifIdValidNext = 1'b1;
            skidFullNext  = 1'b0;
        end else if (accept) begin
            ifIdNext.instr   = imem_rdata;
            ifIdNext.pc      = pcReg;
            ifIdNext.pcPlus4 = pcPlus4;
            ifIdValidNext    = 1'b1;
            pcNext           = pcPlus4;
        end else begin
            ifIdNext.instr = NOP_INSTR;
            ifIdValidNext  = 1'b0;
        end
    end

    assign PCF      = pcReg;
    assign InstrD   = ifId.instr;
    assign PCD      = ifId.pc;
    assign PCPlus4D = ifId.pcPlus4;
    assign ValidD   = ifIdValid;

`ifdef FETCH_PERF_CNT_EN
    logic bubbleLoad;
    logic dropEvent;

    assign bubbleLoad = PCSrcE || FlushD || (!StallD && !skidFull && !accept);
    assign dropEvent  = (accept && (PCSrcE || FlushD)) || ((state == DISCARD) && imem_ready);

    // Bubble and dropped-response counters, frozen while IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt  <= '0;
            discard_cnt <= '0;
        end else if (state != IDLE) begin
            if (bubbleLoad) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (dropEvent) begin
                discard_cnt <= discard_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/skid corner sequence and a randomized
// run checked against an in-order instruction-stream scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NVEC = 34;

    logic        clk;
    logic        reset;
    logic        PCSrcE;
    logic        PCJalSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        StallD;
    logic        FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubbleCnt;
    logic [31:0] discardCnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rdy;
        logic        st;
        logic        fl;
        logic        ps;
        logic        js;
        logic [31:0] tgt;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expPcf;
        logic        expValid;
        logic [31:0] expPcd;
        logic [31:0] expP4;
    } vec_t;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcE     (PCSrcE),
        .PCJalSrcE  (PCJalSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
`ifdef FETCH_PERF_CNT_EN
        .bubble_cnt (bubbleCnt),
        .discard_cnt(discardCnt),
`endif
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic st, input logic fl, input logic ps,
                                input logic js, input logic [31:0] tgt, input logic eReq,
                                input logic [31:0] eAddr, input logic [31:0] ePcf,
                                input logic eValid, input logic [31:0] ePcd,
                                input logic [31:0] eP4);
        vec_t v;
        v.rdy = rdy; v.st = st; v.fl = fl; v.ps = ps; v.js = js; v.tgt = tgt;
        v.expReq = eReq; v.expAddr = eAddr; v.expPcf = ePcf;
        v.expValid = eValid; v.expPcd = ePcd; v.expP4 = eP4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after negedge, act as memory, sample after posedge.
    task automatic runCycle(input logic rdy, input logic st, input logic fl, input logic ps,
                            input logic js, input logic [31:0] tgt,
                            output logic reqSeen, output logic [31:0] addrSeen);
        @(negedge clk);
        imem_ready = rdy;
        StallD     = st;
        FlushD     = fl;
        PCSrcE     = ps;
        PCJalSrcE  = js;
        ALUResultE = js ? tgt : (tgt ^ 32'h0000_F000);
        PCTargetE  = js ? (tgt ^ 32'h0000_F000) : tgt;
        #1;
        reqSeen    = imem_req;
        addrSeen   = imem_addr;
        imem_rdata = instrFor(imem_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[NVEC];
        logic        r;
        logic [31:0] a;
        logic        rdy, st, fl, ps, js;
        logic [31:0] tgt;
        logic [31:0] expPc, prevAddr, oPcd, oP4, oInstr;
        logic        oValid, prevCommit;
        int          gap, maxGap, nValid;

        //            rdy st fl ps js tgt            req addr           pcf            v pcd            p4
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,          0, 32'h0,         32'h0,         0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h0,         32'h4,         1, 32'h0,         32'h4);
        vecs[2]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h4,         32'h8,         1, 32'h4,         32'h8);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h8,         32'h8,         0, 32'h4,         32'h8);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h8,         32'h8,         0, 32'h4,         32'h8);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h8,         32'h8,         0, 32'h4,         32'h8);
        vecs[6]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h8,         32'hC,         1, 32'h8,         32'hC);
        vecs[7]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'hC,         32'h10,        1, 32'hC,         32'h10);
        vecs[8]  = mk(1, 1, 0, 0, 0, 32'h0,          1, 32'h10,        32'h14,        1, 32'hC,         32'h10);
        vecs[9]  = mk(1, 1, 0, 0, 0, 32'h0,          0, 32'h14,        32'h14,        1, 32'hC,         32'h10);
        vecs[10] = mk(1, 0, 0, 0, 0, 32'h0,          0, 32'h14,        32'h14,        1, 32'h10,        32'h14);
        vecs[11] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h14,        32'h18,        1, 32'h14,        32'h18);
        vecs[12] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h18,        32'h1C,        1, 32'h18,        32'h1C);
        vecs[13] = mk(1, 0, 0, 1, 1, 32'h103,        1, 32'h1C,        32'h100,       0, 32'h18,        32'h1C);
        vecs[14] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h100,       32'h104,       1, 32'h100,       32'h104);
        vecs[15] = mk(1, 0, 0, 1, 0, 32'h20,         1, 32'h104,       32'h20,        0, 32'h100,       32'h104);
        vecs[16] = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h20,        32'h20,        0, 32'h100,       32'h104);
        vecs[17] = mk(0, 0, 0, 1, 0, 32'h40,         1, 32'h20,        32'h40,        0, 32'h100,       32'h104);
        vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h20,        32'h40,        0, 32'h100,       32'h104);
        vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h20,        32'h40,        0, 32'h100,       32'h104);
        vecs[20] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h20,        32'h40,        0, 32'h100,       32'h104);
        vecs[21] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h40,        32'h44,        1, 32'h40,        32'h44);
        vecs[22] = mk(1, 0, 0, 1, 0, 32'hFFFF_FFFE,  1, 32'h44,        32'hFFFF_FFFC, 0, 32'h40,        32'h44);
        vecs[23] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);
        vecs[24] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h0,         32'h4,         1, 32'h0,         32'h4);
        vecs[25] = mk(0, 0, 1, 0, 0, 32'h0,          1, 32'h4,         32'h4,         0, 32'h0,         32'h4);
        vecs[26] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h4,         32'h8,         1, 32'h4,         32'h8);
        vecs[27] = mk(0, 1, 1, 0, 0, 32'h0,          1, 32'h8,         32'h8,         0, 32'h4,         32'h8);
        vecs[28] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h8,         32'hC,         1, 32'h8,         32'hC);
        vecs[29] = mk(1, 1, 0, 0, 0, 32'h0,          1, 32'hC,         32'h10,        1, 32'h8,         32'hC);
        vecs[30] = mk(1, 1, 0, 1, 1, 32'h200,        0, 32'h10,        32'h200,       0, 32'h8,         32'hC);
        vecs[31] = mk(1, 1, 0, 0, 0, 32'h0,          1, 32'h200,       32'h204,       0, 32'h8,         32'hC);
        vecs[32] = mk(1, 0, 0, 0, 0, 32'h0,          0, 32'h204,       32'h204,       1, 32'h200,       32'h204);
        vecs[33] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h204,       32'h208,       1, 32'h204,       32'h208);

        reset = 1'b0; PCSrcE = 1'b0; PCJalSrcE = 1'b0; PCTargetE = '0; ALUResultE = '0;
        StallD = 1'b0; FlushD = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pcf", PCF, 32'h0);
        check("reset_valid", 32'(ValidD), 32'd0);
        check("reset_instr", InstrD, NOP);
        check("reset_pcd", PCD, 32'h0);
        check("reset_p4", PCPlus4D, 32'h0);
        check("reset_req", 32'(imem_req), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            runCycle(vecs[i].rdy, vecs[i].st, vecs[i].fl, vecs[i].ps, vecs[i].js, vecs[i].tgt, r, a);
            check($sformatf("v%0d_req", i), 32'(r), 32'(vecs[i].expReq));
            check($sformatf("v%0d_addr", i), a, vecs[i].expAddr);
            check($sformatf("v%0d_pcf", i), PCF, vecs[i].expPcf);
            check($sformatf("v%0d_valid", i), 32'(ValidD), 32'(vecs[i].expValid));
            check($sformatf("v%0d_pcd", i), PCD, vecs[i].expPcd);
            check($sformatf("v%0d_p4", i), PCPlus4D, vecs[i].expP4);
            check($sformatf("v%0d_instr", i), InstrD,
                  vecs[i].expValid ? instrFor(vecs[i].expPcd) : NOP);
        end

        // Fill the skid under stall, then reset asynchronously mid-cycle.
        runCycle(1, 1, 0, 0, 0, 32'h0, r, a);
        check("skid_fill_req", 32'(r), 32'd1);
        check("skid_fill_addr", a, 32'h208);
        runCycle(1, 1, 0, 0, 0, 32'h0, r, a);
        check("skid_full_req", 32'(r), 32'd0);
        check("skid_full_pcd", PCD, 32'h204);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pcf", PCF, 32'h0);
        check("async_rst_valid", 32'(ValidD), 32'd0);
        check("async_rst_instr", InstrD, NOP);
        check("async_rst_pcd", PCD, 32'h0);
        check("async_rst_p4", PCPlus4D, 32'h0);
        check("async_rst_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        runCycle(1, 0, 0, 0, 0, 32'h0, r, a);
        check("refetch_idle_req", 32'(r), 32'd0);
        check("refetch_idle_valid", 32'(ValidD), 32'd0);
        runCycle(1, 0, 0, 0, 0, 32'h0, r, a);
        check("refetch_addr0", a, 32'h0);
        check("refetch_pcd0", PCD, 32'h0);
        check("refetch_instr0", InstrD, instrFor(32'h0));
        runCycle(1, 0, 0, 0, 0, 32'h0, r, a);
        check("refetch_addr4", a, 32'h4);
        check("refetch_pcd4", PCD, 32'h4);

        // Randomized run against the program-order stream model.
        @(negedge clk);
        reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        expPc = 32'h0; prevCommit = 1'b0; prevAddr = '0;
        gap = 0; maxGap = 0; nValid = 0;
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(9) < 7);
            st  = ($urandom_range(9) < 2);
            fl  = ($urandom_range(19) == 0);
            ps  = ($urandom_range(19) == 0);
            js  = 1'($urandom_range(1));
            tgt = $urandom();
            oPcd = PCD; oP4 = PCPlus4D; oInstr = InstrD; oValid = ValidD;
            runCycle(rdy, st, fl, ps, js, tgt, r, a);
            check("rnd_addr_aligned", 32'(a[1:0]), 32'd0);
            if (prevCommit) begin
                check("rnd_hold_req", 32'(r), 32'd1);
                check("rnd_hold_addr", a, prevAddr);
            end
            prevCommit = r && !rdy;
            prevAddr   = a;
            gap++;
            if (ps) begin
                check("rnd_redir_valid", 32'(ValidD), 32'd0);
                check("rnd_redir_instr", InstrD, NOP);
                check("rnd_redir_pcd", PCD, oPcd);
                check("rnd_redir_pcf", PCF, tgt & 32'hFFFF_FFFC);
                expPc = tgt & 32'hFFFF_FFFC;
            end else if (fl) begin
                check("rnd_flush_valid", 32'(ValidD), 32'd0);
                check("rnd_flush_instr", InstrD, NOP);
                check("rnd_flush_pcd", PCD, oPcd);
                check("rnd_flush_p4", PCPlus4D, oP4);
            end else if (st) begin
                check("rnd_stall_valid", 32'(ValidD), 32'(oValid));
                check("rnd_stall_instr", InstrD, oInstr);
                check("rnd_stall_pcd", PCD, oPcd);
                check("rnd_stall_p4", PCPlus4D, oP4);
            end else if (ValidD) begin
                check("rnd_stream_pcd", PCD, expPc);
                check("rnd_stream_instr", InstrD, instrFor(expPc));
                check("rnd_stream_p4", PCPlus4D, expPc + 32'd4);
                expPc = expPc + 32'd4;
                nValid++;
                gap = 0;
            end else begin
                check("rnd_bubble_instr", InstrD, NOP);
                check("rnd_bubble_pcd", PCD, oPcd);
            end
            if (gap > maxGap) maxGap = gap;
        end
        check("rnd_max_gap_ok", 32'(maxGap <= 200), 32'd1);
        check("rnd_enough_valid", 32'(nValid > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
